// File: rtl/useq_pkg.sv
// Shared encodings for the microprogram sequencer: sequencing ops, branch
// conditions, FSM states, the default fetch address and the condition evaluator.
package useq_pkg;

  localparam logic [2:0] SEQ_NEXT     = 3'd0;
  localparam logic [2:0] SEQ_JUMP     = 3'd1;
  localparam logic [2:0] SEQ_COND     = 3'd2;
  localparam logic [2:0] SEQ_DISPATCH = 3'd3;
  localparam logic [2:0] SEQ_FETCH    = 3'd4;
  localparam logic [2:0] SEQ_HALT     = 3'd5;
  localparam logic [2:0] SEQ_CALL     = 3'd6;
  localparam logic [2:0] SEQ_RET      = 3'd7;

  localparam logic [2:0] COND_EQ     = 3'd0;
  localparam logic [2:0] COND_NE     = 3'd1;
  localparam logic [2:0] COND_HI     = 3'd2;
  localparam logic [2:0] COND_HS     = 3'd3;
  localparam logic [2:0] COND_LO     = 3'd4;
  localparam logic [2:0] COND_LS     = 3'd5;
  localparam logic [2:0] COND_ALWAYS = 3'd6;
  localparam logic [2:0] COND_NEVER  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [15:0] FETCH_ADDR_DEF = 16'h0001;

  function automatic logic cond_eval(input logic [2:0] sel, input logic z, input logic c);
    logic r;
    r = 1'b0;
    case (sel)
      COND_EQ:     r = z;
      COND_NE:     r = !z;
      COND_HI:     r = c & !z;
      COND_HS:     r = c;
      COND_LO:     r = !c;
      COND_LS:     r = !c | z;
      COND_ALWAYS: r = 1'b1;
      COND_NEVER:  r = 1'b0;
      default:     r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/useq_stack.sv
// Micro-return-stack LIFO. Push/pop requests that would overflow or underflow
// are ignored here; the sequencer flags them and halts.
module useq_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int SP_W = $clog2(DEPTH + 1);
  localparam int IX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]    mem [DEPTH];
  logic [SP_W-1:0] sp_q;
  logic [SP_W-1:0] sp_dec;
  logic [IX_W-1:0] wr_ix;
  logic [IX_W-1:0] rd_ix;

  assign sp_dec = sp_q - SP_W'(1);
  assign wr_ix  = IX_W'(sp_q);
  assign rd_ix  = IX_W'(sp_dec);
  assign full   = (sp_q == SP_W'(DEPTH));
  assign empty  = (sp_q == '0);
  assign top    = mem[rd_ix];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q <= '0;
    end else if (clr) begin
      sp_q <= '0;
    end else if (push && !full) begin
      sp_q <= sp_q + SP_W'(1);
    end else if (pop && !empty) begin
      sp_q <= sp_dec;
    end
  end

  // Storage needs no reset: an entry is only read after it has been pushed.
  always_ff @(posedge clk) begin
    if (push && !full && !clr) begin
      mem[wr_ix] <= din;
    end
  end

endmodule

// File: rtl/useq_sequencer.sv
// Microprogram sequencer: holds the uPC and picks the next one from seq_op.
// Optional micro-return-stack (CALL/RET) enabled by macro USEQ_STACK_EN.
module useq_sequencer
  import useq_pkg::*;
#(
  parameter int                 UADDR_W     = 16,
  parameter logic [UADDR_W-1:0] FETCH_ADDR  = UADDR_W'(FETCH_ADDR_DEF),
  parameter int                 STACK_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stall,
  input  logic [2:0]         seq_op,
  input  logic [UADDR_W-1:0] uaddr,
  input  logic [2:0]         cond_sel,
  input  logic               flag_z,
  input  logic               flag_c,
  input  logic [UADDR_W-1:0] cu_entry,
  output logic [UADDR_W-1:0] upc,
  output logic               running,
  output logic               halted,
  output logic               dispatch,
  output logic               ustack_err
);

  state_t             state_q, state_d;
  logic [UADDR_W-1:0] upc_q, upc_d;
  logic [UADDR_W-1:0] upc_inc;

  assign upc_inc = upc_q + UADDR_W'(1);

`ifdef USEQ_STACK_EN
  logic               err_q, err_d;
  logic               stk_push, stk_pop, stk_clr;
  logic               stk_full, stk_empty;
  logic [UADDR_W-1:0] stk_top;

  useq_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (UADDR_W)
  ) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (stk_clr),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (upc_inc),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );
`else
  logic unused_stack_cfg;
  assign unused_stack_cfg = ^STACK_DEPTH;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      upc_q   <= FETCH_ADDR;
`ifdef USEQ_STACK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
`ifdef USEQ_STACK_EN
      err_q   <= err_d;
`endif
    end
  end

  // Priority: start (from IDLE/HALT) > stall > seq_op; start is ignored in RUN.
  always_comb begin
    state_d = state_q;
    upc_d   = upc_q;
`ifdef USEQ_STACK_EN
    err_d    = err_q;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    stk_clr  = 1'b0;
`endif
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d = ST_RUN;
          upc_d   = FETCH_ADDR;
`ifdef USEQ_STACK_EN
          err_d   = 1'b0;
          stk_clr = 1'b1;
`endif
        end
      end
      ST_RUN: begin
        if (!stall) begin
          case (seq_op)
            SEQ_NEXT: upc_d = upc_inc;
            SEQ_JUMP: upc_d = uaddr;
            SEQ_COND: upc_d = cond_eval(cond_sel, flag_z, flag_c) ? uaddr : upc_inc;
            SEQ_DISPATCH: begin
              // A zero entry marks HLT or an undefined opcode: stop in place.
              if (cu_entry == '0) begin
                state_d = ST_HALT;
              end else begin
                upc_d = cu_entry;
              end
            end
            SEQ_FETCH: upc_d = FETCH_ADDR;
            SEQ_HALT:  state_d = ST_HALT;
`ifdef USEQ_STACK_EN
            SEQ_CALL: begin
              if (stk_full) begin
                err_d   = 1'b1;
                state_d = ST_HALT;
              end else begin
                stk_push = 1'b1;
                upc_d    = uaddr;
              end
            end
            SEQ_RET: begin
              if (stk_empty) begin
                err_d   = 1'b1;
                state_d = ST_HALT;
              end else begin
                stk_pop = 1'b1;
                upc_d   = stk_top;
              end
            end
`endif
            default: upc_d = upc_inc;
          endcase
        end
      end
      default: begin
        state_d = ST_IDLE;
        upc_d   = FETCH_ADDR;
      end
    endcase
  end

  always_comb begin
    upc      = upc_q;
    running  = (state_q == ST_RUN);
    halted   = (state_q == ST_HALT);
    dispatch = (state_q == ST_RUN) && !stall && (seq_op == SEQ_DISPATCH);
`ifdef USEQ_STACK_EN
    ustack_err = err_q;
`else
    ustack_err = 1'b0;
`endif
  end

endmodule

// File: tb/tb_useq_sequencer.sv
// Directed, table-driven bench for useq_sequencer plus hand-written sequences
// for halt, stall, asynchronous reset and (when USEQ_STACK_EN) the micro-stack.
module tb_useq_sequencer;
  import useq_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         stall = 1'b0;
  logic [2:0]   seq_op = 3'd0;
  logic [W-1:0] uaddr = '0;
  logic [2:0]   cond_sel = 3'd0;
  logic         flag_z = 1'b0;
  logic         flag_c = 1'b0;
  logic [W-1:0] cu_entry = '0;
  logic [W-1:0] upc;
  logic         running, halted, dispatch, ustack_err;

  int n_vec  = 0;
  int n_miss = 0;
  logic [W-1:0] exp_q[$];

  useq_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stall      (stall),
    .seq_op     (seq_op),
    .uaddr      (uaddr),
    .cond_sel   (cond_sel),
    .flag_z     (flag_z),
    .flag_c     (flag_c),
    .cu_entry   (cu_entry),
    .upc        (upc),
    .running    (running),
    .halted     (halted),
    .dispatch   (dispatch),
    .ustack_err (ustack_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         st;
    logic         sl;
    logic [2:0]   op;
    logic [W-1:0] ua;
    logic [2:0]   cs;
    logic         z;
    logic         c;
    logic [W-1:0] ce;
    logic [W-1:0] e_upc;
    logic         e_run;
    logic         e_halt;
    logic         e_disp;
    logic         e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic st, input logic sl, input logic [2:0] op,
                              input logic [W-1:0] ua, input logic [2:0] cs,
                              input logic z, input logic c, input logic [W-1:0] ce,
                              input logic [W-1:0] e_upc, input logic e_run,
                              input logic e_halt, input logic e_disp, input logic e_err);
    vec_t v;
    v.st = st; v.sl = sl; v.op = op; v.ua = ua; v.cs = cs; v.z = z; v.c = c; v.ce = ce;
    v.e_upc = e_upc; v.e_run = e_run; v.e_halt = e_halt; v.e_disp = e_disp; v.e_err = e_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  // Drive on the falling edge, check the combinational strobe before the
  // rising edge and the registered outputs just after it.
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    start = v.st; stall = v.sl; seq_op = v.op; uaddr = v.ua;
    cond_sel = v.cs; flag_z = v.z; flag_c = v.c; cu_entry = v.ce;
    #1;
    check({tag, ".dispatch"}, W'(dispatch), W'(v.e_disp));
    exp_q.push_back(v.e_upc);
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, ".upc"}, upc, exp_q.pop_front());
    check({tag, ".running"}, W'(running), W'(v.e_run));
    check({tag, ".halted"}, W'(halted), W'(v.e_halt));
    check({tag, ".ustack_err"}, W'(ustack_err), W'(v.e_err));
  endtask

  task automatic run_list(input string prefix);
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("%s%0d", prefix, i));
    end
    vecs.delete();
  endtask

  initial begin
    // Reset block: create a real falling edge on rst_n.
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.upc", upc, 16'h0001);
    check("reset.running", W'(running), '0);
    check("reset.halted", W'(halted), '0);
    check("reset.dispatch", W'(dispatch), '0);
    check("reset.ustack_err", W'(ustack_err), '0);
    @(negedge clk);
    rst_n = 1'b1;

    //                 st  sl  op            uaddr     cs           z     c     cu_entry  e_upc     run   halt  disp  err
    vecs.push_back(mk(1'b1,1'b0,SEQ_NEXT,    16'h0000, COND_EQ,    1'b0, 1'b0, 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0,1'b0,SEQ_NEXT,    16'h0000, COND_EQ,    1'b0, 1'b0, 16'h0000, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0,1'b0,SEQ_NEXT,    16'h0000, COND_EQ,    1'b0, 1'b0, 16'h0000, 16'h0003, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0,1'b0,SEQ_NEXT,    16'h0000, COND_EQ,    1'b0, 1'b0, 16'h0000, 16'h0004, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0,1'b0,SEQ_DISPATCH,16'h0000, COND_EQ,    1'b0, 1'b0, 16'h0440, 16'h0440, 1'b1, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0,1'b0,SEQ_COND,    16'h0050, COND_EQ,    1'b1, 1'b0, 16'h0000, 16'h0050, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0,1'b0,SEQ_COND,    16'h0060, COND_EQ,    1'b0, 1'b0, 16'h0000, 16'h0051, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0,1'b0,SEQ_COND,    16'h0070, COND_HI,    1'b1, 1'b1, 16'h0000, 16'h0052, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0,1'b0,SEQ_COND,    16'h0070, COND_HI,    1'b0, 1'b1, 16'h0000, 16'h0070, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0,1'b0,SEQ_COND,    16'h0080, COND_NE,    1'b0, 1'b0, 16'h0000, 16'h0080, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0,1'b0,SEQ_COND,    16'h0090, COND_LS,    1'b0, 1'b1, 16'h0000, 16'h0081, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0,1'b0,SEQ_COND,    16'h00a0, COND_LO,    1'b0, 1'b0, 16'h0000, 16'h00a0, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0,1'b0,SEQ_COND,    16'h00b0, COND_HS,    1'b0, 1'b0, 16'h0000, 16'h00a1, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0,1'b0,SEQ_COND,    16'h00c0, COND_ALWAYS,1'b0, 1'b0, 16'h0000, 16'h00c0, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0,1'b0,SEQ_COND,    16'h00d0, COND_NEVER, 1'b1, 1'b1, 16'h0000, 16'h00c1, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1,1'b0,SEQ_NEXT,    16'h0000, COND_EQ,    1'b0, 1'b0, 16'h0000, 16'h00c2, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0,1'b0,SEQ_JUMP,    16'hffff, COND_EQ,    1'b0, 1'b0, 16'h0000, 16'hffff, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0,1'b0,SEQ_NEXT,    16'h0000, COND_EQ,    1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0,1'b0,SEQ_FETCH,   16'h0000, COND_EQ,    1'b0, 1'b0, 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0,1'b1,SEQ_JUMP,    16'h1234, COND_EQ,    1'b0, 1'b0, 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0,1'b1,SEQ_DISPATCH,16'h0000, COND_EQ,    1'b0, 1'b0, 16'h0440, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0,1'b0,SEQ_JUMP,    16'h0300, COND_EQ,    1'b0, 1'b0, 16'h0000, 16'h0300, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0,1'b0,SEQ_DISPATCH,16'h0000, COND_EQ,    1'b0, 1'b0, 16'h0000, 16'h0300, 1'b0, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0,1'b1,SEQ_NEXT,    16'h0000, COND_EQ,    1'b0, 1'b0, 16'h0000, 16'h0300, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0,1'b0,SEQ_JUMP,    16'h0400, COND_EQ,    1'b0, 1'b0, 16'h0000, 16'h0300, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1,1'b1,SEQ_JUMP,    16'h0400, COND_EQ,    1'b0, 1'b0, 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0,1'b0,SEQ_NEXT,    16'h0000, COND_EQ,    1'b0, 1'b0, 16'h0000, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0,1'b0,SEQ_HALT,    16'h0500, COND_EQ,    1'b0, 1'b0, 16'h0000, 16'h0002, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1,1'b0,SEQ_NEXT,    16'h0000, COND_EQ,    1'b0, 1'b0, 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0));
`ifdef USEQ_STACK_EN
    vecs.push_back(mk(1'b0,1'b0,SEQ_CALL,    16'h0100, COND_EQ,    1'b0, 1'b0, 16'h0000, 16'h0100, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0,1'b0,SEQ_RET,     16'h0000, COND_EQ,    1'b0, 1'b0, 16'h0000, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0));
`else
    vecs.push_back(mk(1'b0,1'b0,SEQ_CALL,    16'h0100, COND_EQ,    1'b0, 1'b0, 16'h0000, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0,1'b0,SEQ_RET,     16'h0000, COND_EQ,    1'b0, 1'b0, 16'h0000, 16'h0003, 1'b1, 1'b0, 1'b0, 1'b0));
`endif
    run_list("tbl");

    // Stall held for three cycles: upc frozen, no dispatch strobe.
    vecs.push_back(mk(1'b0,1'b0,SEQ_JUMP,    16'h0040, COND_EQ,    1'b0, 1'b0, 16'h0000, 16'h0040, 1'b1, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      vecs.push_back(mk(1'b0,1'b1,SEQ_DISPATCH,16'h0000, COND_EQ,  1'b0, 1'b0, 16'h0777, 16'h0040, 1'b1, 1'b0, 1'b0, 1'b0));
    end
    run_list("stall");

    // Reset asserted mid-stall, away from any clock edge.
    @(negedge clk);
    stall = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.upc", upc, 16'h0001);
    check("async_rst.running", W'(running), '0);
    check("async_rst.halted", W'(halted), '0);
    check("async_rst.dispatch", W'(dispatch), '0);
    @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0;
    vecs.push_back(mk(1'b0,1'b0,SEQ_JUMP,    16'h0600, COND_EQ,    1'b0, 1'b0, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1,1'b0,SEQ_NEXT,    16'h0000, COND_EQ,    1'b0, 1'b0, 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0));
    run_list("post_rst");

`ifdef USEQ_STACK_EN
    // Single call/return, then return on an empty stack.
    vecs.push_back(mk(1'b0,1'b0,SEQ_JUMP,    16'h0020, COND_EQ,    1'b0, 1'b0, 16'h0000, 16'h0020, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0,1'b0,SEQ_CALL,    16'h0100, COND_EQ,    1'b0, 1'b0, 16'h0000, 16'h0100, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0,1'b0,SEQ_RET,     16'h0000, COND_EQ,    1'b0, 1'b0, 16'h0000, 16'h0021, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0,1'b0,SEQ_RET,     16'h0000, COND_EQ,    1'b0, 1'b0, 16'h0000, 16'h0021, 1'b0, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0,1'b0,SEQ_NEXT,    16'h0000, COND_EQ,    1'b0, 1'b0, 16'h0000, 16'h0021, 1'b0, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1,1'b0,SEQ_NEXT,    16'h0000, COND_EQ,    1'b0, 1'b0, 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0));
    // Four nested calls fill the stack, the fifth overflows.
    for (int i = 0; i < 4; i++) begin
      vecs.push_back(mk(1'b0,1'b0,SEQ_CALL,  16'h0200, COND_EQ,    1'b0, 1'b0, 16'h0000, 16'h0200, 1'b1, 1'b0, 1'b0, 1'b0));
    end
    vecs.push_back(mk(1'b0,1'b0,SEQ_CALL,    16'h0800, COND_EQ,    1'b0, 1'b0, 16'h0000, 16'h0200, 1'b0, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1,1'b0,SEQ_NEXT,    16'h0000, COND_EQ,    1'b0, 1'b0, 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0));
    run_list("stack");
`else
    vecs.push_back(mk(1'b0,1'b0,SEQ_JUMP,    16'h0020, COND_EQ,    1'b0, 1'b0, 16'h0000, 16'h0020, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0,1'b0,SEQ_CALL,    16'h0100, COND_EQ,    1'b0, 1'b0, 16'h0000, 16'h0021, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0,1'b0,SEQ_RET,     16'h0000, COND_EQ,    1'b0, 1'b0, 16'h0000, 16'h0022, 1'b1, 1'b0, 1'b0, 1'b0));
    run_list("nostack");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/useq_sequencer.md
# useq_sequencer

Microprogram sequencer for the micro-programmed control unit. Holds the micro-program counter (uPC) that addresses control memory, and each cycle picks the next uPC from the current microinstruction's sequencing field. The choices are increment, jump, flag-conditional branch, dispatch to the opcode entry address from the opcode decoder, return to fetch, or halt. Sits between the opcode decoder, the flag register and control memory.

## Interface
Parameters:
- UADDR_W, 16, uPC / micro-address width; equals decoder entry width.
- FETCH_ADDR, 16'h0001, micro-address of the instruction-fetch routine.
- STACK_DEPTH, 4, micro-return-stack entries (only with USEQ_STACK_EN).

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  1-cycle pulse: leave IDLE/HALT, begin at FETCH_ADDR.
- stall  in  1  hold uPC and state (datapath/memory busy).
- seq_op  in  3  sequencing field of current microinstruction.
- uaddr  in  UADDR_W  target field of current microinstruction.
- cond_sel  in  3  condition select for COND.
- flag_z  in  1  zero flag.
- flag_c  in  1  carry flag.
- cu_entry  in  UADDR_W  entry address from the opcode decoder.
- upc  out  UADDR_W  control-memory address.
- running  out  1  state == RUN.
- halted  out  1  state == HALT.
- dispatch  out  1  DISPATCH taken this cycle; IR/opcode sampling strobe.
- ustack_err  out  1  sticky micro-stack overflow/underflow.

## Operation
- States: IDLE (after reset), RUN, HALT.
- IDLE/HALT + start -> RUN, uPC <= FETCH_ADDR, stack pointer <= 0, ustack_err <= 0.
- RUN + start: start ignored.
- RUN with stall=1: nothing changes, dispatch=0.
- RUN with stall=0, next uPC by seq_op:
  - 0 NEXT: uPC+1, wraps modulo 2^UADDR_W.
  - 1 JUMP: uaddr.
  - 2 COND: uaddr if condition true, else uPC+1.
  - 3 DISPATCH: cu_entry. If cu_entry == 0 (HLT or undefined opcode), go to HALT and hold uPC.
  - 4 FETCH: FETCH_ADDR.
  - 5 HALT: go to HALT and hold uPC.
  - 6 CALL / 7 RET: see Configuration.
- cond_sel conditions:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 HI: C&!Z
  - 3 HS: C
  - 4 LO: !C
  - 5 LS: !C|Z
  - 6 ALWAYS: 1
  - 7 NEVER: 0
- dispatch = running & !stall & (seq_op==3). Combinational output; asserted even when the dispatch leads to HALT.

## Timing
- Reset values: state IDLE, upc = FETCH_ADDR, running 0, halted 0, dispatch 0, ustack_err 0, stack pointer 0.
- Reset assertion mid-operation forces these values immediately, independent of clk.
- upc, running, halted and ustack_err are registered. Decision inputs are sampled on the clock edge, and the new upc is visible one cycle later.
- Control memory is read combinationally from upc, so the microinstruction for upc is valid in the same cycle. Throughput is one microinstruction per unstalled cycle.
- Flags are sampled in the same cycle as the COND microinstruction.
- Precedence: rst_n > start (from IDLE/HALT) > stall > seq_op.

## Configuration
- Macro: USEQ_STACK_EN.
- Defined: micro-return-stack of STACK_DEPTH × UADDR_W.
  - CALL pushes uPC+1 and jumps to uaddr.
  - RET pops into uPC.
  - CALL when full, or RET when empty: ustack_err <= 1, enter HALT, stack unchanged.
- Undefined: CALL and RET behave as NEXT, ustack_err is tied to 0, and no stack storage is built.

## Structure
- Shared package useq_pkg holds:
  - seq_op encodings (SEQ_NEXT..SEQ_RET);
  - cond_sel encodings (COND_EQ..COND_NEVER);
  - state enum (ST_IDLE, ST_RUN, ST_HALT);
  - default FETCH_ADDR constant.
- Sub-module useq_stack: LIFO with push/pop/full/empty, instantiated only under USEQ_STACK_EN.

## Test plan
- Reset then start; NEXT ×3 -> upc 0x0001, 0x0002, 0x0003, 0x0004; running=1.
- DISPATCH with cu_entry=0x0440 (ADD entry) -> dispatch=1 that cycle, upc=0x0440 next cycle.
- COND cond_sel=EQ, uaddr=0x0050 -> with Z=1, upc=0x0050; with Z=0, upc+1. HI with C=1,Z=1 -> not taken.
- DISPATCH with cu_entry=0 -> halted=1 and upc held; stall ignored afterwards; start -> upc=0x0001, running=1.
- NEXT at upc=0xFFFF -> upc=0x0000. stall=1 for 3 cycles during RUN -> upc constant; rst_n low mid-stall -> immediate IDLE, upc=0x0001.
- With USEQ_STACK_EN: CALL 0x0100 at upc=0x0020 -> upc=0x0100, RET -> upc=0x0021. Five nested CALLs -> ustack_err=1, halted=1. Without the macro, CALL -> upc+1.
